// File: rtl/nand2_stim_seq.sv
// nand2_stim_seq: stimulus sequencer and self-checker for a 2-input NAND.
// It walks {a,b} through 00, 01, 10, 11 and holds each vector for HOLD_CYCLES
// cycles. It then spends one cycle sampling y_in against ~(a&b).
// Mismatches are counted in a saturating counter, and the whole sweep is
// repeated REPEAT times per run. The outcome is reported through done/pass.
module nand2_stim_seq #(
  parameter int HOLD_CYCLES = 2,
  parameter int REPEAT      = 1,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             y_in,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       vec_idx
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // The hold counter counts 0..HOLD_CYCLES-1 and the pass counter counts
  // 0..REPEAT-1, so each is sized for its largest value. Both are at least 1 bit.
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int PASS_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(REPEAT - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

  logic [1:0]        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [PASS_W-1:0] pass_cnt;
  logic              expected_y;
  logic              mismatch;
  logic [ERR_W-1:0]  err_next;

  // In IDLE and DONE, vec_idx is parked at 0. Tying a/b straight to the
  // vec_idx flops therefore keeps them registered and at 0 outside a run.
  assign a = vec_idx[1];
  assign b = vec_idx[0];

  // Reference NAND result for the current vector. The case inequality makes an
  // X/Z on y_in count as a mismatch. The error count saturates at all-ones.
  always_comb begin
    expected_y = ~(vec_idx[1] & vec_idx[0]);
    mismatch   = (y_in !== expected_y);
    err_next   = err_count;
    if (mismatch && (err_count != ERR_MAX)) begin
      err_next = err_count + ERR_W'(1);
    end
  end

  // Sequencer FSM. Reset aborts any run in progress and discards its result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      pass_cnt  <= '0;
      vec_idx   <= 2'd0;
      err_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= DRIVE;
            hold_cnt  <= '0;
            pass_cnt  <= '0;
            vec_idx   <= 2'd0;
            err_count <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
        DRIVE: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            state    <= SAMPLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        SAMPLE: begin
          err_count <= err_next;
          if (vec_idx != 2'd3) begin
            vec_idx <= vec_idx + 2'd1;
            state   <= DRIVE;
          end else if (pass_cnt != PASS_LAST) begin
            pass_cnt <= pass_cnt + PASS_W'(1);
            vec_idx  <= 2'd0;
            state    <= DRIVE;
          end else begin
            vec_idx <= 2'd0;
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_next == '0);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
